// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCK/WS/SD on clk_i, deserialises one left and one
// right word per frame, and presents the stereo pair through a valid/ready
// handshake. A pair that completes while the previous pair is still unaccepted
// is dropped and flagged; a WS edge before a word completes drops the frame and
// the receiver re-aligns on the next left-channel WS edge.
module i2s_rx #(
  parameter int   DATA_WIDTH = 24,
  parameter int   SLOT_BITS  = 32,
  parameter logic WS_POL     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  sync_err_o
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_DONE = CW'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } state_t;

  // Input pipelines (identical depth keeps SCK, WS and SD aligned)
  logic [1:0] sck_pipe, ws_pipe, sd_pipe;
  logic       sck_prev, ws_prev;
  logic       sck_p, ws_p, sd_p;
  logic       sck_rise, ws_edge;

  // Frame tracking
  state_t                state_q, state_d;
  logic                  sync_err_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  left_ok;
  logic                  cap_en;
  logic                  last_bit;

  // Completed pair waiting for the output stage
  logic                  pair_pend;
  logic [DATA_WIDTH-1:0] pair_right;

  // Two-flop pipeline on every I2S line plus one history flop for edge detection
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, regardless of statement order.
    if (rst_i) begin
      sck_pipe <= '0;
      ws_pipe  <= '0;
      sd_pipe  <= '0;
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      sck_pipe <= {sck_pipe[0], sck_i};
      ws_pipe  <= {ws_pipe[0], ws_i};
      sd_pipe  <= {sd_pipe[0], sd_i};
      sck_prev <= sck_pipe[1];
      ws_prev  <= ws_pipe[1];
    end
  end

  assign sck_p    = sck_pipe[1];
  assign ws_p     = ws_pipe[1];
  assign sd_p     = sd_pipe[1];
  assign sck_rise = sck_p & ~sck_prev;
  assign ws_edge  = ws_p ^ ws_prev;

  // Bit capture window: count 0 is the previous slot's LSB, counts beyond
  // DATA_WIDTH are slot padding.
  assign cap_en   = sck_rise && !ws_edge && (state_q != ST_SYNC) &&
                    (cnt_q != '0) && (cnt_q <= CNT_LAST);
  assign last_bit = cap_en && (cnt_q == CNT_LAST);
  assign shift_nx = {shift_q, sd_p};

  // Next-state logic: channel alternation on WS edges, resync on short slots
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    sync_err_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (ws_edge && (ws_p == WS_POL)) state_d = ST_LEFT;
      end
      ST_LEFT: begin
        if (ws_edge) begin
          if (cnt_q < CNT_DONE) begin
            state_d    = ST_SYNC;
            sync_err_d = 1'b1;
          end else begin
            state_d = ST_RIGHT;
          end
        end
      end
      ST_RIGHT: begin
        if (ws_edge) begin
          if (cnt_q < CNT_DONE) begin
            state_d    = ST_SYNC;
            sync_err_d = 1'b1;
          end else begin
            state_d = ST_LEFT;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // Frame state, bit counter, shift register and channel holding registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_SYNC;
      sync_err_o <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
      pair_pend  <= 1'b0;
      pair_right <= '0;
    end else begin
      state_q    <= state_d;
      sync_err_o <= sync_err_d;
      pair_pend  <= 1'b0;

      if (ws_edge) begin
        cnt_q <= '0;
      end else if (sck_rise && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (cap_en) shift_q <= shift_nx[DATA_WIDTH-2:0];

      // A left word is only usable by the right word of the same frame:
      // forget it on resync and at the start of every new frame.
      if ((state_d == ST_SYNC) || ((state_q == ST_RIGHT) && (state_d == ST_LEFT))) begin
        left_ok <= 1'b0;
      end else if (last_bit && (state_q == ST_LEFT)) begin
        left_hold <= shift_nx;
        left_ok   <= 1'b1;
      end

      if (last_bit && (state_q == ST_RIGHT) && left_ok) begin
        pair_pend  <= 1'b1;
        pair_right <= shift_nx;
      end
    end
  end

  // Output stage: load a completed pair when the slot is free or being emptied
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_o    <= '0;
      right_o   <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (pair_pend) begin
        if (!valid_o || ready_i) begin
          left_o  <= left_hold;
          right_o <= pair_right;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: frame-level stimulus on SCK/WS/SD with a
// queue-based pair model, a table of fixed frames, random frames, and
// hand-written sequences for backpressure, resync and reset.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int   DW     = 24;
  localparam int   SLOT   = 32;
  localparam logic WS_POL = 1'b0;

  logic          clk = 1'b0;
  logic          rst_i, sck_i, ws_i, sd_i, ready_i;
  logic [DW-1:0] left_o, right_o;
  logic          valid_o, overrun_o, sync_err_o;

  i2s_rx #(.DATA_WIDTH(DW), .SLOT_BITS(SLOT), .WS_POL(WS_POL)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .sck_i     (sck_i),
    .ws_i      (ws_i),
    .sd_i      (sd_i),
    .left_o    (left_o),
    .right_o   (right_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o),
    .sync_err_o(sync_err_o)
  );

  // ~27 MHz system clock
  always #18.5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered by the monitor
  logic [2*DW-1:0] got_q[$];
  int ovr_cnt   = 0;
  int serr_cnt  = 0;
  int vhigh_cnt = 0;
  int vlow_cnt  = 0;
  logic            prev_valid = 1'b0;
  logic            prev_hs    = 1'b0;
  logic [2*DW-1:0] prev_out   = '0;

  // Reference model: every complete, in-sync frame yields exactly its pair
  logic [2*DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          dly;
    logic          pad;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, once inputs have settled
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_i) begin
      if (valid_o) vhigh_cnt++; else vlow_cnt++;
      if (overrun_o) ovr_cnt++;
      if (sync_err_o) serr_cnt++;
      if (prev_valid && !prev_hs && valid_o)
        check("hold_stable", 64'({left_o, right_o}), 64'(prev_out));
      if (valid_o && ready_i) got_q.push_back({left_o, right_o});
      prev_valid = valid_o;
      prev_hs    = valid_o && ready_i;
      prev_out   = {left_o, right_o};
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  // One SCK period (4 clk low, 4 clk high); act=1 pulses ready on the cycle a
  // pair completes on this rising edge, act=2 pulses reset during the high phase.
  task automatic sck_period(input logic w, input logic d, input int act);
    sck_i = 1'b0;
    ws_i  = w;
    sd_i  = d;
    repeat (4) @(negedge clk);
    sck_i = 1'b1;
    if (act == 1) begin
      repeat (3) @(negedge clk);
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
    end else if (act == 2) begin
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("rst_pulse_valid", 64'(valid_o), 64'd0);
      check("rst_pulse_left",  64'(left_o),  64'd0);
      check("rst_pulse_right", 64'(right_o), 64'd0);
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // n SCK periods of one slot: delay bit, DW data bits MSB first, padding
  task automatic drive_slot(input logic w, input logic [DW-1:0] data, input logic dly,
                            input logic pad, input int n, input int act_p, input int act);
    for (int p = 0; p < n; p++) begin
      logic d;
      if (p == 0) d = dly;
      else if (p <= DW) d = data[DW-p];
      else d = pad;
      sck_period(w, d, (p == act_p) ? act : 0);
    end
  endtask

  task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic dly, input logic pad);
    drive_slot(WS_POL,  l, dly, pad, SLOT, -1, 0);
    drive_slot(~WS_POL, r, dly, pad, SLOT, -1, 0);
  endtask

  task automatic expect_pair(input string name, input logic [2*DW-1:0] exp);
    check({name, "_count"}, 64'(got_q.size()), 64'd1);
    if (got_q.size() != 0) check(name, 64'(got_q.pop_front()), 64'(exp));
    got_q.delete();
  endtask

  initial begin
    int ob, sb, vb, lb;
    logic [DW-1:0] l, r;
    logic dly, pad;

    vecs[0] = '{24'h123456, 24'hA5A5A5, 1'b0, 1'b0, 24'h123456, 24'hA5A5A5};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 1'b1, 1'b1, 24'h800000, 24'h7FFFFF};
    vecs[2] = '{24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 24'h000000, 24'hFFFFFF};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 24'hFFFFFF, 24'h000000};
    vecs[4] = '{24'h5A5A5A, 24'h0F0F0F, 1'b1, 1'b0, 24'h5A5A5A, 24'h0F0F0F};

    rst_i = 1'b1; sck_i = 1'b0; ws_i = ~WS_POL; sd_i = 1'b0; ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_valid",    64'(valid_o),    64'd0);
    check("reset_left",     64'(left_o),     64'd0);
    check("reset_right",    64'(right_o),    64'd0);
    check("reset_overrun",  64'(overrun_o),  64'd0);
    check("reset_sync_err", 64'(sync_err_o), 64'd0);
    rst_i = 1'b0;

    // Tail of a right slot so the first left slot starts with a WS edge
    drive_slot(~WS_POL, '0, 1'b0, 1'b0, 4, -1, 0);
    check("sync_quiet", 64'(got_q.size()), 64'd0);

    // Table-driven frames, first one is the first full frame after reset
    for (int i = 0; i < 5; i++) begin
      vb = vhigh_cnt;
      drive_frame(vecs[i].l, vecs[i].r, vecs[i].dly, vecs[i].pad);
      check($sformatf("tbl%0d_valid_cycles", i), 64'(vhigh_cnt - vb), 64'd1);
      expect_pair($sformatf("tbl%0d", i), {vecs[i].exp_l, vecs[i].exp_r});
    end

    // Random frames against the pair queue model
    ob = ovr_cnt; sb = serr_cnt;
    for (int k = 0; k < 12; k++) begin
      l = DW'($urandom()); r = DW'($urandom());
      dly = 1'($urandom_range(1)); pad = 1'($urandom_range(1));
      exp_q.push_back({l, r});
      drive_frame(l, r, dly, pad);
      expect_pair($sformatf("rand%0d", k), exp_q.pop_front());
    end
    check("rand_no_overrun", 64'(ovr_cnt - ob),  64'd0);
    check("rand_no_syncerr", 64'(serr_cnt - sb), 64'd0);

    // Backpressure for two frames: first pair held, second dropped
    ready_i = 1'b0; ob = ovr_cnt; got_q.delete();
    drive_frame(24'h111111, 24'h222222, 1'b0, 1'b0);
    drive_frame(24'h333333, 24'h444444, 1'b1, 1'b1);
    check("ovr_valid_held", 64'(valid_o), 64'd1);
    check("ovr_outputs", 64'({left_o, right_o}), 64'({24'h111111, 24'h222222}));
    check("ovr_pulses", 64'(ovr_cnt - ob), 64'd1);
    check("ovr_no_hs", 64'(got_q.size()), 64'd0);
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    expect_pair("ovr_drain", {24'h111111, 24'h222222});
    check("ovr_valid_drop", 64'(valid_o), 64'd0);
    drive_frame(24'h555555, 24'h666666, 1'b0, 1'b0);
    expect_pair("ovr_next", {24'h555555, 24'h666666});

    // Handshake in the exact completion cycle of the next pair
    ready_i = 1'b0;
    drive_frame(24'hABCDEF, 24'h012345, 1'b0, 1'b0);
    check("cont_held", 64'({left_o, right_o}), 64'({24'hABCDEF, 24'h012345}));
    ob = ovr_cnt; lb = vlow_cnt; got_q.delete();
    drive_slot(WS_POL,  24'hFEDCBA, 1'b0, 1'b0, SLOT, -1, 0);
    drive_slot(~WS_POL, 24'h6789AB, 1'b0, 1'b0, SLOT, DW, 1);
    expect_pair("cont_old_taken", {24'hABCDEF, 24'h012345});
    check("cont_valid_gap", 64'(vlow_cnt - lb), 64'd0);
    check("cont_no_overrun", 64'(ovr_cnt - ob), 64'd0);
    check("cont_valid", 64'(valid_o), 64'd1);
    check("cont_new_loaded", 64'({left_o, right_o}), 64'({24'hFEDCBA, 24'h6789AB}));
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    expect_pair("cont_new_taken", {24'hFEDCBA, 24'h6789AB});

    // WS toggles after 10 SCK in the left slot
    sb = serr_cnt; got_q.delete();
    drive_slot(WS_POL,  24'h999999, 1'b0, 1'b0, 10, -1, 0);
    drive_slot(~WS_POL, 24'h888888, 1'b0, 1'b0, SLOT, -1, 0);
    check("serr_pulse", 64'(serr_cnt - sb), 64'd1);
    check("serr_no_out", 64'(got_q.size()), 64'd0);
    drive_frame(24'h13579B, 24'h2468AC, 1'b1, 1'b0);
    expect_pair("serr_recover", {24'h13579B, 24'h2468AC});
    check("serr_single", 64'(serr_cnt - sb), 64'd1);

    // Reset pulse mid right slot while a pair is held
    ready_i = 1'b0;
    drive_frame(24'h0A0A0A, 24'h0B0B0B, 1'b0, 1'b0);
    check("rst_pre_valid", 64'(valid_o), 64'd1);
    got_q.delete();
    drive_slot(WS_POL,  24'h0C0C0C, 1'b0, 1'b0, SLOT, -1, 0);
    drive_slot(~WS_POL, 24'h0D0D0D, 1'b0, 1'b0, SLOT, 12, 2);
    ready_i = 1'b1;
    check("rst_no_out", 64'(got_q.size()), 64'd0);
    drive_frame(24'hC0FFEE, 24'hBEEF01, 1'b0, 1'b1);
    expect_pair("rst_recover", {24'hC0FFEE, 24'hBEEF01});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 24; captured bits per channel (MSB-first), range 8..32.
REQ-002 Parameter SLOT_BITS, default 32; SCK periods per WS half-frame, SHALL be >= DATA_WIDTH+1.
REQ-003 Parameter WS_POL, default 1'b0; WS level that denotes the left channel.
REQ-004 clk_i  input  1  system clock (27 MHz); the only clock.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 sck_i  input  1  I2S bit clock; synchronous to clk_i, at least 2 clk_i cycles per level.
REQ-007 ws_i  input  1  I2S word select; changes only on SCK falling edges.
REQ-008 sd_i  input  1  serial data from microphone; asynchronous to clk_i.
REQ-009 left_o  output  DATA_WIDTH  left sample, two's complement, as received.
REQ-010 right_o  output  DATA_WIDTH  right sample, two's complement, as received.
REQ-011 valid_o  output  1  stereo pair available on left_o/right_o.
REQ-012 ready_i  input  1  consumer accepts the pair when valid_o && ready_i.
REQ-013 overrun_o  output  1  one-cycle pulse: completed pair dropped because valid_o was still held.
REQ-014 sync_err_o  output  1  one-cycle pulse: WS toggled before DATA_WIDTH bits were captured.

Function
REQ-015 sck_i, ws_i, sd_i SHALL each pass through an identical 2-flop pipeline; all edge detection and sampling SHALL use the pipelined copies, so the three stay mutually aligned.
REQ-016 SCK rising edge = pipelined sck high this cycle and low the previous cycle; WS edge = pipelined ws differs from its previous value.
REQ-017 States: SYNC, LEFT, RIGHT.
REQ-018 SYNC -> LEFT on a WS edge to WS_POL; every other event in SYNC SHALL be ignored.
REQ-019 LEFT -> RIGHT on a WS edge to ~WS_POL; RIGHT -> LEFT on a WS edge to WS_POL.
REQ-020 Bit counter SHALL reset to 0 on every WS edge and increment on each SCK rising edge, saturating at SLOT_BITS.
REQ-021 I2S one-bit delay: the rising edge at count 0 SHALL be discarded (previous-slot LSB); counts 1..DATA_WIDTH SHALL shift sd into the channel register MSB first; counts > DATA_WIDTH SHALL be ignored.
REQ-022 When count DATA_WIDTH is sampled in LEFT, the left holding register SHALL be updated.
REQ-023 When count DATA_WIDTH is sampled in RIGHT, the pair SHALL be complete; on the next clk_i cycle, left_o/right_o SHALL be loaded and valid_o asserted, provided valid_o is low or is being handshaken in the same cycle.
REQ-024 If a pair completes while valid_o=1 and ready_i=0, the outputs SHALL be unchanged, the new pair discarded, and overrun_o pulsed.
REQ-025 Completion and a handshake in the same cycle: the new pair SHALL be loaded and valid_o SHALL stay 1, with no overrun.
REQ-026 valid_o SHALL deassert in the cycle after a handshake when no new pair loads; left_o/right_o SHALL stay stable while valid_o=1.
REQ-027 A WS edge in LEFT/RIGHT with count < DATA_WIDTH+1 SHALL discard the partial frame, pulse sync_err_o, and enter SYNC; a WS edge to WS_POL in that same cycle SHALL NOT count as the SYNC exit.
REQ-028 A right channel SHALL only pair with the left channel of the same frame; the first frame after SYNC SHALL NOT output a pair until both of its channels are complete.

Reset
REQ-029 While rst_i=1 at clk_i: state=SYNC, counter=0, pipelines=0, left_o=right_o=0, valid_o=0, overrun_o=0, sync_err_o=0.
REQ-030 Reset asserted mid-frame or with valid_o=1 SHALL drop all data; after release, no output until a fresh WS edge to WS_POL and a complete frame.

Verification
REQ-031 Driven by a 27 MHz / SCK_DIV=8 clock generator model (SLOT_BITS=32, WS_POL=0), with left=0x123456 and right=0xA5A5A5 on sd and ready_i=1 -> one valid_o pulse per frame with left_o=0x123456 and right_o=0xA5A5A5; first pair in the first full frame after reset.
REQ-032 Left=0x800000, right=0x7FFFFF, sd=1 on the delay bit and sd=1 on bits 25..32 -> outputs exactly 0x800000 and 0x7FFFFF (padding and delay bit ignored).
REQ-033 ready_i=0 for two frames -> first pair held, overrun_o pulses once at the second completion, outputs unchanged; when ready_i rises, handshake occurs and the next pair is from the following frame.
REQ-034 ready_i asserted in the exact cycle the next pair completes -> new pair loaded, valid_o continuous, no overrun.
REQ-035 WS toggled after 10 SCK in the left slot -> sync_err_o pulse, no output for that frame, correct pair from the next complete frame.
REQ-036 rst_i pulsed for 1 cycle mid right slot with valid_o=1 -> valid_o=0 next cycle, outputs 0, next valid pair only after a full new frame.
